// File: rtl/uart_boot_loader.sv
// uart_boot_loader: UART boot-stream receiver (auto-baud on 0xFF, "CAFE" sync, word count, word writes).
// Defining LOADER_CHECKSUM_EN adds a trailing 32-bit word-sum check before the load is accepted.
module uart_boot_loader #(
  parameter int          CNT_W      = 16,
  parameter logic [31:0] MAGIC      = 32'h43414645,
  parameter logic [31:0] BASE_ADDR  = 32'h00000000,
  parameter int          MIN_PERIOD = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx,
  output logic             wr_valid,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  input  logic             wr_ready,
  output logic             cpu_hold,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] bit_period
);
`ifdef LOADER_CHECKSUM_EN
  localparam logic CSUM_EN = 1'b1;
`else
  localparam logic CSUM_EN = 1'b0;
`endif

  localparam logic [1:0] AB_IDLE = 2'd0, AB_MEAS = 2'd1, AB_RUN = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;
  localparam logic [2:0] P_HUNT = 3'd0, P_COUNT = 3'd1, P_DATA = 3'd2, P_SUM = 3'd3, P_DONE = 3'd4;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             rx_meta, rx_sync, rx_prev, rx_fall;
  logic [1:0]       ab_state;
  logic [CNT_W-1:0] ab_cnt;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_timer, half_period;
  logic [2:0]       r_bits;
  logic [7:0]       r_shift, byte_data;
  logic             byte_strobe, frame_err;
  logic [2:0]       p_state;
  logic [31:0]      window, next_window, remaining, rx_left, sum;
  logic [1:0]       byte_cnt;
  logic             handshake, finish_now;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall     = rx_prev & ~rx_sync;
  assign half_period = bit_period >> 1;

  // Auto-baud: the start bit of 0xFF is the only low stretch, so its length is one bit period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ab_state   <= AB_IDLE;
      ab_cnt     <= '0;
      bit_period <= '0;
    end else begin
      case (ab_state)
        AB_IDLE: if (rx_fall) begin
          ab_state <= AB_MEAS;
          ab_cnt   <= CNT_ONE;
        end
        AB_MEAS: begin
          if (!rx_sync) begin
            if (ab_cnt != {CNT_W{1'b1}}) ab_cnt <= ab_cnt + CNT_ONE;
          end else if (ab_cnt >= CNT_W'(MIN_PERIOD)) begin
            bit_period <= ab_cnt;
            ab_state   <= AB_RUN;
          end else begin
            ab_state <= AB_IDLE;
          end
        end
        default: ab_state <= AB_RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= R_IDLE;
      r_timer     <= '0;
      r_bits      <= '0;
      r_shift     <= '0;
      byte_data   <= '0;
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
      case (r_state)
        R_IDLE: if (ab_state == AB_RUN && rx_fall) begin
          r_state <= R_START;
          r_timer <= CNT_ONE;
        end
        R_START: begin
          if (r_timer >= half_period) begin
            r_timer <= CNT_ONE;
            r_bits  <= '0;
            r_state <= rx_sync ? R_IDLE : R_DATA;
          end else begin
            r_timer <= r_timer + CNT_ONE;
          end
        end
        R_DATA: begin
          if (r_timer >= bit_period) begin
            r_shift <= {rx_sync, r_shift[7:1]};
            r_timer <= CNT_ONE;
            r_bits  <= r_bits + 3'd1;
            if (r_bits == 3'd7) r_state <= R_STOP;
          end else begin
            r_timer <= r_timer + CNT_ONE;
          end
        end
        default: begin
          if (r_timer >= bit_period) begin
            r_state <= R_IDLE;
            if (rx_sync) begin
              byte_strobe <= 1'b1;
              byte_data   <= r_shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign next_window = {window[23:0], byte_data};
  assign handshake   = wr_valid & wr_ready;
  assign finish_now  = !CSUM_EN && handshake && (p_state == P_DATA) && (remaining == 32'd1);
  assign cpu_hold    = ~done;

  // A pending write always drains, even after the parser has fallen back to hunting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_state   <= P_HUNT;
      window    <= '0;
      byte_cnt  <= '0;
      remaining <= '0;
      rx_left   <= '0;
      sum       <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= BASE_ADDR;
      wr_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (handshake) begin
        wr_valid  <= 1'b0;
        wr_addr   <= wr_addr + 32'd4;
        remaining <= remaining - 32'd1;
        if (finish_now) begin
          p_state <= P_DONE;
          done    <= 1'b1;
        end
      end
      if (frame_err && p_state != P_DONE && !finish_now) begin
        err      <= 1'b1;
        p_state  <= P_HUNT;
        window   <= '0;
        byte_cnt <= '0;
      end else if (byte_strobe) begin
        case (p_state)
          P_HUNT: begin
            window <= next_window;
            if (next_window == MAGIC) begin
              p_state  <= P_COUNT;
              byte_cnt <= '0;
              sum      <= '0;
              if (!wr_valid) wr_addr <= BASE_ADDR;
            end
          end
          P_COUNT: begin
            window   <= next_window;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              remaining <= next_window;
              rx_left   <= next_window;
              if (next_window != 32'd0) p_state <= P_DATA;
              else if (CSUM_EN) p_state <= P_SUM;
              else begin
                p_state <= P_DONE;
                done    <= 1'b1;
              end
            end
          end
          P_DATA: if (rx_left != 32'd0) begin
            window   <= next_window;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (wr_valid && !wr_ready) begin
                err     <= 1'b1;
                p_state <= P_HUNT;
                window  <= '0;
              end else begin
                wr_valid <= 1'b1;
                wr_data  <= next_window;
                sum      <= sum + next_window;
                rx_left  <= rx_left - 32'd1;
                if (CSUM_EN && rx_left == 32'd1) p_state <= P_SUM;
              end
            end
          end
          P_SUM: begin
            window   <= next_window;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (next_window == sum) begin
                p_state <= P_DONE;
                done    <= 1'b1;
              end else begin
                err     <= 1'b1;
                p_state <= P_HUNT;
                window  <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: 16-clock bit period (the shortest accepted), 3 idle bits per byte.
module tb_uart_boot_loader;
  localparam int P = 16;
  localparam logic [31:0] MAGIC = 32'h43414645;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic        wr_ready = 1'b1;
  logic        wr_valid, cpu_hold, done, err;
  logic [31:0] wr_addr, wr_data;
  logic [15:0] bit_period;

  int n_checks = 0;
  int n_fail   = 0;
  int bit_time = P;
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] prog [8] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h002081b3,
                            32'h00302023, 32'h00002203, 32'h00418233, 32'hff9ff06f};

  always #5 clock = ~clock;

  uart_boot_loader dut (
    .clock(clock), .reset(reset), .rx(rx),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .cpu_hold(cpu_hold), .done(done), .err(err), .bit_period(bit_period)
  );

  // wr_ready only changes shortly after a rising edge, so the falling edge sees the handshake settled.
  always @(negedge clock) begin
    if (reset && wr_valid && wr_ready) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
      $display("write #%0d addr=%08h data=%08h", got_data.size() - 1, wr_addr, wr_data);
    end
  end

  initial begin
    repeat (95000) @(posedge clock);
    $display("FAIL watchdog: run exceeded 95000 cycles");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (bit_time) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bit_time) @(negedge clock);
    end
    rx = stop_bit;
    repeat (bit_time) @(negedge clock);
    rx = 1'b1;
    repeat (3 * bit_time) @(negedge clock);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic send_magic_count(input logic [31:0] n);
    send_word(MAGIC);
    send_word(n);
  endtask

  task automatic send_prog_words();
    for (int i = 0; i < 8; i++) send_word(prog[i]);
  endtask

`ifdef LOADER_CHECKSUM_EN
  function automatic logic [31:0] prog_sum();
    logic [31:0] s = 32'd0;
    for (int i = 0; i < 8; i++) s = s + prog[i];
    return s;
  endfunction
`endif

  task automatic do_reset();
    @(posedge clock); #2;
    reset = 1'b0; rx = 1'b1; wr_ready = 1'b1; bit_time = P;
    repeat (3) @(posedge clock); #2;
    got_addr.delete();
    got_data.delete();
    reset = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
    n_checks++; if (wr_addr !== 32'h0) begin n_fail++; $display("FAIL reset_wr_addr: got %08h expected 00000000", wr_addr); end
    n_checks++; if (wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wr_data: got %08h expected 00000000", wr_data); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_hold: got %b expected 1", cpu_hold); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++; if (bit_period !== 16'd0) begin n_fail++; $display("FAIL reset_bit_period: got %0d expected 0", bit_period); end
    $display("test_reset complete");
  endtask

  task automatic test_full_load();
    do_reset();
    send_byte(8'hFF, 1'b1);
    send_magic_count(32'd8);
    send_prog_words();
`ifdef LOADER_CHECKSUM_EN
    send_word(prog_sum());
`endif
    n_checks++; if (bit_period !== 16'(P)) begin n_fail++; $display("FAIL full_bit_period: got %0d expected %0d", bit_period, P); end
    n_checks++; if (got_data.size() != 8) begin n_fail++; $display("FAIL full_write_count: got %0d expected 8", got_data.size()); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= got_data.size()) begin
        n_fail++; $display("FAIL full_write_%0d: missing, expected %08h at %08h", i, prog[i], 4 * i);
      end else if (got_addr[i] !== 32'(4 * i) || got_data[i] !== prog[i]) begin
        n_fail++; $display("FAIL full_write_%0d: got %08h@%08h expected %08h@%08h", i, got_data[i], got_addr[i], prog[i], 4 * i);
      end
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b expected 1", done); end
    n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL full_cpu_hold: got %b expected 0", cpu_hold); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL full_err: got %b expected 0", err); end
    send_word(32'h0badf00d);
    n_checks++; if (got_data.size() != 8) begin n_fail++; $display("FAIL full_after_done: got %0d writes expected 8", got_data.size()); end
    $display("test_full_load complete");
  endtask

  task automatic test_garbage();
    do_reset();
    send_byte(8'hFF, 1'b1);
    send_magic_count(32'd8);
    send_word(prog[0]);
    send_word(prog[1]);
    n_checks++; if (got_data.size() != 2) begin n_fail++; $display("FAIL midload_writes: got %0d expected 2", got_data.size()); end
    do_reset();
    n_checks++; if (bit_period !== 16'd0) begin n_fail++; $display("FAIL midload_bit_period: got %0d expected 0", bit_period); end
    n_checks++; if (wr_addr !== 32'h0) begin n_fail++; $display("FAIL midload_addr: got %08h expected 00000000", wr_addr); end
    send_byte(8'hFF, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h43, 1'b1);
    send_magic_count(32'd8);
    send_prog_words();
`ifdef LOADER_CHECKSUM_EN
    send_word(prog_sum());
`endif
    n_checks++; if (got_data.size() != 8) begin n_fail++; $display("FAIL garbage_write_count: got %0d expected 8", got_data.size()); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= got_data.size()) begin
        n_fail++; $display("FAIL garbage_write_%0d: missing, expected %08h", i, prog[i]);
      end else if (got_addr[i] !== 32'(4 * i) || got_data[i] !== prog[i]) begin
        n_fail++; $display("FAIL garbage_write_%0d: got %08h@%08h expected %08h@%08h", i, got_data[i], got_addr[i], prog[i], 4 * i);
      end
    end
    n_checks++; if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL garbage_status: got done=%b err=%b expected done=1 err=0", done, err); end
    $display("test_garbage complete");
  endtask

  task automatic test_framing();
    do_reset();
    send_byte(8'hFF, 1'b1);
    send_word(MAGIC);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL framing_err: got %b expected 1", err); end
    n_checks++; if (got_data.size() != 0) begin n_fail++; $display("FAIL framing_no_write: got %0d writes expected 0", got_data.size()); end
    send_magic_count(32'd1);
    send_word(32'h12345678);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'h12345678);
`endif
    n_checks++; if (got_data.size() != 1) begin n_fail++; $display("FAIL framing_resync_count: got %0d expected 1", got_data.size()); end
    else if (got_data[0] !== 32'h12345678 || got_addr[0] !== 32'h0) begin
      n_fail++; $display("FAIL framing_resync_write: got %08h@%08h expected 12345678@00000000", got_data[0], got_addr[0]);
    end
    n_checks++; if (done !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL framing_status: got done=%b err=%b expected done=1 err=1", done, err); end
    $display("test_framing complete");
  endtask

  task automatic test_overrun();
    do_reset();
    send_byte(8'hFF, 1'b1);
    send_magic_count(32'd3);
    @(posedge clock); #2; wr_ready = 1'b0;
    send_word(32'hdeadbeef);
    n_checks++; if (wr_valid !== 1'b1 || wr_data !== 32'hdeadbeef || wr_addr !== 32'h0) begin
      n_fail++; $display("FAIL overrun_pending: got valid=%b %08h@%08h expected 1 deadbeef@00000000", wr_valid, wr_data, wr_addr);
    end
    send_word(32'hcafef00d);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL overrun_err: got %b expected 1", err); end
    n_checks++; if (wr_valid !== 1'b1 || wr_data !== 32'hdeadbeef) begin
      n_fail++; $display("FAIL overrun_stable: got valid=%b data=%08h expected 1 deadbeef", wr_valid, wr_data);
    end
    @(posedge clock); #2; wr_ready = 1'b1;
    for (int k = 0; k < 20 && got_data.size() == 0; k++) @(negedge clock);
    repeat (2) @(negedge clock);
    n_checks++; if (got_data.size() != 1) begin n_fail++; $display("FAIL overrun_drain: got %0d writes expected 1", got_data.size()); end
    else if (got_data[0] !== 32'hdeadbeef) begin n_fail++; $display("FAIL overrun_data: got %08h expected deadbeef", got_data[0]); end
    n_checks++; if (wr_valid !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b1) begin
      n_fail++; $display("FAIL overrun_after: got valid=%b done=%b hold=%b expected 0 0 1", wr_valid, done, cpu_hold);
    end
    send_word(32'h11223344);
    n_checks++; if (got_data.size() != 1) begin n_fail++; $display("FAIL overrun_hunt: got %0d writes expected 1", got_data.size()); end
    $display("test_overrun complete");
  endtask

  task automatic test_count_zero_glitch();
    do_reset();
    bit_time = 8;
    send_byte(8'hFF, 1'b1);
    n_checks++; if (bit_period !== 16'd0) begin n_fail++; $display("FAIL short_period_rejected: got %0d expected 0", bit_period); end
    bit_time = P;
    send_byte(8'hFF, 1'b1);
    n_checks++; if (bit_period !== 16'(P)) begin n_fail++; $display("FAIL min_period_accepted: got %0d expected %0d", bit_period, P); end
    send_word(MAGIC);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
    rx = 1'b0;
    repeat (5) @(negedge clock);
    rx = 1'b1;
    repeat (3 * P) @(negedge clock);
    send_byte(8'h00, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'h0);
`endif
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b expected 1", done); end
    n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL zero_cpu_hold: got %b expected 0", cpu_hold); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL zero_err: got %b expected 0", err); end
    n_checks++; if (got_data.size() != 0) begin n_fail++; $display("FAIL zero_writes: got %0d expected 0", got_data.size()); end
    $display("test_count_zero_glitch complete");
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    do_reset();
    send_byte(8'hFF, 1'b1);
    send_magic_count(32'd8);
    send_prog_words();
    send_word(prog_sum() + 32'd1);
    n_checks++; if (got_data.size() != 8) begin n_fail++; $display("FAIL badsum_writes: got %0d expected 8", got_data.size()); end
    n_checks++; if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
      n_fail++; $display("FAIL badsum_status: got err=%b done=%b hold=%b expected 1 0 1", err, done, cpu_hold);
    end
    $display("test_bad_checksum complete");
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_garbage();
    test_framing();
    test_overrun();
    test_count_zero_glitch();
`ifdef LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
